// File: rtl/fp_to_fixed_converter.sv
// fp_to_fixed_converter
// Converts an IEEE-754 single-precision operand to signed two's-complement
// fixed point (OUT_W bits, FRAC_BITS fractional). The float is unpacked, the
// hidden bit restored, and the significand is denormalised one bit per cycle.
// Valid/ready on both sides, one operation in flight.
//
// Optional build macro: FP2FIX_ROUND_NEAREST_EN
//   defined   -> right-shift results round to nearest, ties away from zero
//   undefined -> truncation toward zero (no guard register)
//
// state | meaning
// IDLE  | ready for an operand
// SHIFT | denormalising; count==0 registers the result
// DONE  | result presented, waiting for out_ready
module fp_to_fixed_converter #(
    parameter int OUT_W     = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_exc
);

    localparam int CNT_W = 7;
    localparam logic signed [11:0] K_EDGE = 12'(OUT_W - 24);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [2:0] {K_NORM, K_ZERO, K_EXC, K_PSAT, K_NSAT} kind_t;

    state_t            r_state, w_state_nxt;
    kind_t             r_kind, w_kind;
    logic              r_sign;
    logic              r_dir_right;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic [OUT_W-1:0]  r_mag;
    logic              r_out_valid;
    logic [OUT_W-1:0]  r_out_data;
    logic              r_out_sat;
    logic              r_out_exc;

    logic              w_accept;
    logic              w_finish;
    logic              w_release;
    logic [7:0]        w_exp;
    logic [22:0]       w_man;
    logic signed [11:0] w_k;
    logic signed [11:0] w_k_neg;
    logic [OUT_W-1:0]  w_mag_fin;
    logic [OUT_W-1:0]  w_result;

    assign w_exp     = in_data[30:23];
    assign w_man     = in_data[22:0];
    assign w_k       = $signed({4'b0000, w_exp}) - 12'sd150 + $signed(12'(FRAC_BITS));
    assign w_k_neg   = -w_k;

    assign in_ready  = (r_state == IDLE);
    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_finish  = (r_state == SHIFT) && (r_cnt == '0);
    assign w_release = r_out_valid && out_ready;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign out_exc   = r_out_exc;

    // Classify the incoming operand and pick shift count; specials skip shifting
    always_comb begin
        w_kind = K_NORM;
        w_cnt  = '0;
        if (w_exp == 8'h00) begin
            w_kind = K_ZERO;
        end else if (w_exp == 8'hFF) begin
            w_kind = K_EXC;
        end else if (!w_k[11]) begin
            if (!in_data[31] && (w_k >= K_EDGE)) begin
                w_kind = K_PSAT;
            end else if (in_data[31] && ((w_k > K_EDGE) || ((w_k == K_EDGE) && (w_man != '0)))) begin
                w_kind = K_NSAT;
            end else begin
                w_cnt = w_k[CNT_W-1:0];
            end
        end else begin
            // anything past 25 right shifts is already zero with a zero guard
            if (w_k_neg > 12'sd25) begin
                w_cnt = CNT_W'(25);
            end else begin
                w_cnt = w_k_neg[CNT_W-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)         w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == '0)      w_state_nxt = DONE;
            DONE:    if (out_ready)        w_state_nxt = IDLE;
            default:                       w_state_nxt = IDLE;
        endcase
    end

    // Operand latch, one-bit-per-cycle shifter and result/flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kind      <= K_NORM;
            r_sign      <= 1'b0;
            r_dir_right <= 1'b0;
            r_cnt       <= '0;
            r_mag       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_exc   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_kind      <= w_kind;
                r_sign      <= in_data[31];
                r_dir_right <= w_k[11];
                r_cnt       <= w_cnt;
                r_mag       <= {{(OUT_W-24){1'b0}}, 1'b1, w_man};
            end else if ((r_state == SHIFT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
                if (r_dir_right) begin
                    r_mag <= r_mag >> 1;
                end else begin
                    r_mag <= r_mag << 1;
                end
            end

            if (w_finish) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_result;
                r_out_sat   <= (r_kind == K_PSAT) || (r_kind == K_NSAT);
                r_out_exc   <= (r_kind == K_EXC);
            end else if (w_release) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef FP2FIX_ROUND_NEAREST_EN
    logic r_guard;

    // Remember the last bit pushed out by a right shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_guard <= 1'b0;
        end else if (w_accept) begin
            r_guard <= 1'b0;
        end else if ((r_state == SHIFT) && (r_cnt != '0) && r_dir_right) begin
            r_guard <= r_mag[0];
        end
    end

    // Round half away from zero: add guard to the magnitude before negation
    assign w_mag_fin = r_mag + (r_dir_right ? {{(OUT_W-1){1'b0}}, r_guard} : '0);
`else
    assign w_mag_fin = r_mag;
`endif

    // Final value: signed magnitude for normal operands, fixed codes for specials
    always_comb begin
        w_result = '0;
        case (r_kind)
            K_NORM:  w_result = r_sign ? (~w_mag_fin + 1'b1) : w_mag_fin;
            K_PSAT:  w_result = {1'b0, {(OUT_W-1){1'b1}}};
            K_NSAT:  w_result = {1'b1, {(OUT_W-1){1'b0}}};
            default: w_result = '0;
        endcase
    end

endmodule

// File: tb/tb_fp_to_fixed_converter.sv
// Testbench for fp_to_fixed_converter: directed cases, backpressure, mid-shift
// reset and random operands checked against an arithmetic reference model.
module tb_fp_to_fixed_converter;

    localparam int OUT_W     = 32;
    localparam int FRAC_BITS = 16;
`ifdef FP2FIX_ROUND_NEAREST_EN
    localparam logic [31:0] EXP_37C = 32'h0000_0002;
`else
    localparam logic [31:0] EXP_37C = 32'h0000_0001;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;
    logic             out_exc;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp_to_fixed_converter #(.OUT_W(OUT_W), .FRAC_BITS(FRAC_BITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .out_exc(out_exc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // value = (-1)^s * sig * 2^(E-150), scaled by 2^FRAC_BITS, then quantised
    function automatic void ref_model(input logic [31:0] d, output logic [OUT_W-1:0] m_data,
                                      output logic m_sat, output logic m_exc, output int m_lat);
        int e, k, r;
        logic [127:0] sig, mag, lim;
        bit big;
        e = int'(d[30:23]);
        sig = {104'd0, 1'b1, d[22:0]};
        m_data = '0; m_sat = 1'b0; m_exc = 1'b0; m_lat = 1;
        if (e == 0) return;
        if (e == 255) begin m_exc = 1'b1; return; end
        k = e - 150 + FRAC_BITS;
        if (k >= 0) begin
            big = (k > 64);
            mag = big ? 128'd0 : (sig << k);
            lim = d[31] ? (128'd1 << (OUT_W-1)) : ((128'd1 << (OUT_W-1)) - 128'd1);
            if (big || mag > lim) begin
                m_sat  = 1'b1;
                m_data = d[31] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            end else begin
                m_lat  = 1 + k;
                m_data = d[31] ? OUT_W'(-mag) : OUT_W'(mag);
            end
        end else begin
            r = -k;
            m_lat = 1 + ((r > 25) ? 25 : r);
            mag = sig >> r;
`ifdef FP2FIX_ROUND_NEAREST_EN
            if (r <= 24) mag = mag + 128'(sig[r-1]);
`endif
            m_data = d[31] ? OUT_W'(-mag) : OUT_W'(mag);
        end
    endfunction

    // Issue one operand, wait for the result, compare, then accept it
    task automatic run_core(input logic [31:0] d, input string tag, input logic [OUT_W-1:0] e_data,
                            input logic e_sat, input logic e_exc, input int e_lat);
        int lat;
        @(negedge clk);
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, " latency"}, 64'(lat), 64'(e_lat));
        check({tag, " data"}, 64'(out_data), 64'(e_data));
        check({tag, " sat"}, 64'(out_sat), 64'(e_sat));
        check({tag, " exc"}, 64'(out_exc), 64'(e_exc));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " valid_drop"}, 64'(out_valid), 64'd0);
    endtask

    task automatic run_model(input logic [31:0] d, input string tag);
        logic [OUT_W-1:0] m_data;
        logic m_sat, m_exc;
        int m_lat;
        ref_model(d, m_data, m_sat, m_exc, m_lat);
        run_core(d, tag, m_data, m_sat, m_exc, m_lat);
    endtask

    initial begin
        logic [31:0] d;
        int seen, lat;

        repeat (2) @(negedge clk);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_data", 64'(out_data), 64'd0);
        check("rst out_sat", 64'(out_sat), 64'd0);
        check("rst out_exc", 64'(out_exc), 64'd0);
        rst_n = 1'b1;

        run_core(32'h3F80_0000, "one",    32'h0001_0000, 1'b0, 1'b0, 8);
        run_core(32'hC020_0000, "m2p5",   32'hFFFD_8000, 1'b0, 1'b0, 7);
        run_core(32'hC700_0000, "m32768", 32'h8000_0000, 1'b0, 1'b0, 9);
        run_core(32'h4780_0000, "p65536", 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        run_core(32'hC780_0000, "m65536", 32'h8000_0000, 1'b1, 1'b0, 1);
        run_core(32'h7FC0_0000, "nan",    32'h0000_0000, 1'b0, 1'b1, 1);
        run_core(32'h0000_0001, "denorm", 32'h0000_0000, 1'b0, 1'b0, 1);
        run_core(32'h37C0_0000, "round",  EXP_37C,       1'b0, 1'b0, 24);
        run_core(32'h3380_0000, "tiny",   32'h0000_0000, 1'b0, 1'b0, 26);

        // backpressure: hold the result, an in_valid pulse must be ignored
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("bp latency", 64'(lat), 64'd8);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_valid = 1'b1;
                in_data  = 32'h4000_0000;
            end
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            check("bp hold data", 64'(out_data), 64'h0001_0000);
            check("bp hold valid", 64'(out_valid), 64'd1);
            check("bp in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp release valid", 64'(out_valid), 64'd0);
        check("bp release in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("bp pulse ignored", 64'(seen), 64'd0);
        run_core(32'h4000_0000, "b2b_a", 32'h0002_0000, 1'b0, 1'b0, 7);
        run_model(32'h4040_0000, "b2b_b");

        // mid-shift reset: outputs must clear asynchronously, nothing emitted
        run_core(32'h4780_0000, "pre_rst", 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst in_ready", 64'(in_ready), 64'd1);
        check("arst out_valid", 64'(out_valid), 64'd0);
        check("arst out_data", 64'(out_data), 64'd0);
        check("arst out_sat", 64'(out_sat), 64'd0);
        check("arst out_exc", 64'(out_exc), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("arst no result", 64'(seen), 64'd0);
        run_core(32'h3F80_0000, "post_rst", 32'h0001_0000, 1'b0, 1'b0, 8);

        // random operands, exponents biased toward the representable window
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                d = $urandom;
            end else begin
                d[31]    = 1'($urandom_range(0, 1));
                d[30:23] = 8'($urandom_range(100, 145));
                d[22:0]  = 23'($urandom);
            end
            run_model(d, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
